// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, diff = a - b - bin, LSB first, one
//               full-subtractor cell and a borrow flip-flop, valid/ready
//               handshake on operand and result sides.
//               Optional feature macro: SERIAL_SUB_OVF_EN (adds the ovf port
//               and two's-complement overflow flag).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  // Operand side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  // Result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // Counter value at which the MSB bit-step is performed
  localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] c_CNT_ZERO = '0;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  // Partial result: the bits produced so far, already right-aligned towards
  // the MSB. Only WIDTH-1 bits are needed because the final bit is combined
  // directly into the output register on the last step.
  logic [WIDTH-2:0] part_q,   part_d;
  // Presented result; only updated on the final bit-step so no partial value
  // is ever visible on diff/bout.
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q,    ovf_d;
`endif

  // --------------------------------------------------------------------------
  // Full-subtractor cell
  // --------------------------------------------------------------------------
  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_bnext;
  logic [WIDTH-1:0] w_shift;
  logic             w_last_step;

  assign w_x     = a_sr_q[0];
  assign w_y     = b_sr_q[0];
  assign w_d     = w_x ^ w_y ^ borrow_q;
  assign w_bnext = (~w_x & w_y) | (~(w_x ^ w_y) & borrow_q);

  // New difference bit enters at the MSB; on the last step this is the full
  // result, otherwise its upper WIDTH-1 bits become the next partial value.
  assign w_shift     = {w_d, part_q};
  assign w_last_step = (cnt_q == c_CNT_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic: handshake FSM plus one bit-step per RUN cycle
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    part_d   = part_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      c_IDLE: begin
        // in_ready is a decode of IDLE, so in_valid alone means accept
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          cnt_d    = c_CNT_ZERO;
          part_d   = '0;
          state_d  = c_RUN;
        end
      end

      c_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = w_bnext;
        part_d   = w_shift[WIDTH-1:1];
        cnt_d    = cnt_q + c_CNT_ONE;
        if (w_last_step) begin
          diff_d  = w_shift;
          bout_d  = w_bnext;
`ifdef SERIAL_SUB_OVF_EN
          // Borrow into the sign bit differing from borrow out of it is
          // exactly two's-complement overflow of the subtraction.
          ovf_d   = borrow_q ^ w_bnext;
`endif
          state_d = c_DONE;
        end
      end

      c_DONE: begin
        if (out_ready) begin
          state_d = c_IDLE;
        end
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Register update with asynchronous abort to the reset values
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= c_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= c_CNT_ZERO;
      part_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      part_q   <= part_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registers or direct state decodes only
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == c_IDLE);
  assign out_valid = (state_q == c_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=4).
//               Table of directed vectors plus hand-written sequences for
//               backpressure and mid-operation reset. Checks ovf when
//               SERIAL_SUB_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
    .bout      (bout),
    .ovf       (ovf)
`else
    .bout      (bout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full operation with out_ready held high before out_valid
  task automatic do_op(input string name, input logic [3:0] va, input logic [3:0] vb,
                       input logic vbin, input logic [3:0] ed, input logic eb,
                       input logic eo);
    int lat;
    int w;
    @(negedge clk);
    a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);                 // E0: accept
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_no_early_valid"}, {31'd0, out_valid}, 32'd0);
    lat = 0;
    // Edges E1.. until out_valid, bounded
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    chk({name, "_latency"}, lat, WIDTH);
    chk({name, "_diff"}, {28'd0, diff}, {28'd0, ed});
    chk({name, "_bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: ovf expectation unknown for %s", name);
`endif
    // Early out_ready: DONE lasts exactly one cycle
    @(posedge clk);
    #1;
    chk({name, "_done_1cyc"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_ready_again"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;

    //            a     b     bin   diff  bout  ovf
    vecs[0] = '{4'h7, 4'h3, 1'b0, 4'h4, 1'b0, 1'b0};
    vecs[1] = '{4'h3, 4'h7, 1'b0, 4'hC, 1'b1, 1'b0};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{4'h5, 4'hF, 1'b1, 4'h5, 1'b1, 1'b0};
    vecs[4] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
    vecs[5] = '{4'h2, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0};
    vecs[6] = '{4'h6, 4'h6, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[7] = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[8] = '{4'h0, 4'hF, 1'b0, 4'h1, 1'b1, 1'b0};

    // Reset values, sampled while reset is asserted
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff",      {28'd0, diff},      32'd0);
    chk("rst_bout",      {31'd0, bout},      32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
            vecs[i].exp_diff, vecs[i].exp_bout, vecs[i].exp_ovf);
    end

    // Backpressure: hold out_ready low in DONE, poke in_valid
    begin
      int w;
      @(negedge clk);
      a = 4'hA; b = 4'h3; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);                // accept
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("bp_reach_done", {31'd0, out_valid}, 32'd1);
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1; a = 4'h1; b = 4'h1; bin = 1'b1;
        @(negedge clk);
        chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
        chk("bp_diff_hold",  {28'd0, diff},      32'h7);
        chk("bp_bout_hold",  {31'd0, bout},      32'd0);
        chk("bp_in_ready",   {31'd0, in_ready},  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_idle",  {31'd0, in_ready},  32'd1);
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_diff_kept",     {28'd0, diff},      32'h7);
    end

    // Reset two cycles into RUN
    @(negedge clk);
    a = 4'hC; b = 4'h2; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);                  // accept
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);                  // E1
    @(posedge clk);                  // E2
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_diff",      {28'd0, diff},      32'd0);
    chk("mrst_bout",      {31'd0, bout},      32'd0);
    chk("mrst_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_op("after_rst", 4'h9, 4'h4, 1'b0, 4'h5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
